// File: rtl/regbank_write_arbiter_if.sv
// Write-request / read-port bundle between datapath requesters and the register bank.
// The bank takes the slave side; the requesters take the master side.
interface regbank_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 2,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [AW*NREQ-1:0] wr_addr;
  logic [DW*NREQ-1:0] wr_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               busy;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;

  modport master (
    output req, wr_addr, wr_data, rd_addr,
    input  gnt, ack, busy, rd_data
  );

  modport slave (
    input  req, wr_addr, wr_data, rd_addr,
    output gnt, ack, busy, rd_data
  );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Flop-based register bank with a single write path shared round-robin among NREQ
// requesters; one write per two cycles, one-cycle ack, combinational read port.
module regbank_write_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  regbank_write_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [PW-1:0]   win_reg, win_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   data_reg, data_next;
  logic [DW*NREG-1:0] bank_flat;

  logic sel_found;
  int   sel_idx;
  int   scan_idx;

  // Round-robin scan starting at ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 0;
    scan_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(ptr_reg) + k) % NREQ;
      if (!sel_found && bus.req[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    gnt_next   = gnt_reg;
    ack_next   = '0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          win_next   = PW'(sel_idx);
          gnt_next   = NREQ'(1) << sel_idx;
          addr_next  = bus.wr_addr[sel_idx*AW +: AW];
          data_next  = bus.wr_data[sel_idx*DW +: DW];
          state_next = WRITE;
        end
      end
      WRITE: begin
        // The register itself is written on this same edge by the bank below.
        ack_next   = gnt_reg;
        gnt_next   = '0;
        ptr_next   = (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + PW'(1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses at or beyond NREG match no register, so such writes simply vanish.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [DW-1:0] q_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_reg <= '0;
      end else if (state_reg == WRITE && int'(addr_reg) == gi) begin
        q_reg <= data_reg;
      end
    end
    assign bank_flat[gi*DW +: DW] = q_reg;
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(bus.rd_addr) == i) begin
        bus.rd_data = bank_flat[i*DW +: DW];
      end
    end
  end

  assign bus.gnt  = gnt_reg;
  assign bus.ack  = ack_reg;
  assign bus.busy = (state_reg == WRITE);

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
Shared bank of 8-bit registers, each built as a positive-edge clocked flop, with one write path. Several datapath requesters compete for that write path. The block arbitrates among them round-robin, commits the winner's data into the addressed register, and returns a one-cycle acknowledge. It also provides one combinational read port for downstream datapath logic.

Parameters:
NREQ, 4, number of write requesters
NREG, 4, number of 8-bit registers in the bank
AW, 2, register address width
DW, 8, register data width

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester write request; bit i belongs to requester i
wr_addr  input  AW*NREQ  flattened write addresses; requester i uses bits [AW*i +: AW]
wr_data  input  DW*NREQ  flattened write data; requester i uses bits [DW*i +: DW]
gnt  output  NREQ  registered one-hot grant; high during the WRITE state only
ack  output  NREQ  one-cycle pulse to the winner when its write commits
busy  output  1  high while the FSM is in WRITE
rd_addr  input  AW  read address
rd_data  output  DW  combinational read of register rd_addr

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE; ptr = 0.
  - All registers = 0.
  - gnt, ack and busy = 0; latched address and data = 0.
- FSM states are IDLE and WRITE.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select winner w: the first set req bit scanning ptr, ptr+1, … NREQ-1, 0, … with wrap-around.
  - Latch wr_addr[w] and wr_data[w]; set gnt = one-hot(w); go to WRITE.
- WRITE, exactly one cycle:
  - On the closing edge, register[latched addr] <= latched data.
  - Pulse ack[w] for the cycle after that edge.
  - Update ptr = (w+1) mod NREQ.
  - Clear gnt and return to IDLE.
- Timing:
  - Request accepted at edge N enters WRITE.
  - Write commits at edge N+1, when ack goes high.
  - Earliest next grant is at edge N+2, so peak throughput is one write every 2 cycles.
- Handshake:
  - A requester holds req, wr_addr and wr_data stable until its ack.
  - Data is latched at grant, so changes after grant are ignored.
  - req still high in the ack cycle counts as a new request; it is arbitrated normally with lowest priority behind the updated ptr.
  - req is sampled only in IDLE; requests raised or dropped during WRITE have no effect on the current write.
- Fairness:
  - A continuously requesting requester waits at most NREQ grants.
  - With all req high, grant order cycles 0,1,2,3,0,…
- ack is never asserted for more than one cycle or for more than one requester at a time.
- Read port:
  - rd_data = register[rd_addr], purely combinational.
  - No write bypass: the new value is visible at rd_data from the edge that commits it onward.
- Address range:
  - A latched address >= NREG discards the write, but ack is still issued and ptr still advances.
  - rd_addr >= NREG returns 0.
- Reset mid-operation: rst asserted in WRITE aborts the write; no register changes, no ack, and state and ptr return to reset values.
- Widths: no arithmetic on data. ptr is sized ceil(log2 NREQ) and wraps to 0 after NREQ-1.

Test Plan:
- Reset check: rst high, then release.
  -> rd_data = 0x00 for all rd_addr 0..3; gnt = 0, ack = 0, busy = 0.
- Single write: req = 0001, addr0 = 2, data0 = 0xA5, held until ack.
  -> gnt = 0001 and busy = 1 for one cycle; ack = 0001 one cycle later; rd_addr = 2 reads 0xA5 from that edge.
- Contention: req = 1111 held, data i = 0x10+i, addr i = i, each requester drops req after its ack.
  -> acks in order 0001, 0010, 0100, 1000, spaced 2 cycles apart; registers 0..3 read 0x10..0x13.
- Round-robin pointer: grant to requester 2 first, then req = 0101.
  -> next grant goes to requester 0 (scan 3, 0), not 2; then requester 2.
- Held request: requester 1 keeps req high after ack while requester 3 also requests.
  -> requester 3 is granted before requester 1's second grant.
- Reset in WRITE: assert rst during the WRITE cycle for a write of 0xFF to reg 1.
  -> reg 1 stays 0x00, no ack pulse, busy = 0 immediately.
